// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with valid/ready, stall, flush and optional skid slot
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter bit SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t           state;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             take;

  assign take   = out_valid && out_ready && !stall;
  assign accept = in_valid && in_ready;

  // With the skid slot, ready depends only on registered state, breaking the ready chain.
  assign in_ready = SKID ? !skid_valid : (!out_valid || take);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      occupancy  <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            out_valid <= 1'b1;
            out_data  <= in_data;
            occupancy <= 2'd1;
          end
        end
        ONE: begin
          if (accept && take) begin
            out_data <= in_data;
          end else if (accept && SKID) begin
            state      <= TWO;
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            occupancy  <= 2'd2;
          end else if (take) begin
            // Bubble: emptied main slot reads as a NOP.
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            occupancy <= 2'd0;
          end
        end
        TWO: begin
          if (take) begin
            state      <= ONE;
            out_data   <= skid_data;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            occupancy  <= 2'd1;
          end
        end
        default: begin
          state      <= EMPTY;
          out_valid  <= 1'b0;
          out_data   <= '0;
          skid_valid <= 1'b0;
          skid_data  <= '0;
          occupancy  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed vector bench for pipe_stage_reg (SKID=1 table, SKID=0 sequence)
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic        s_rst_n, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_stall, s_flush;
  logic [31:0] s_in_data, s_out_data;
  logic [1:0]  s_occ;

  // SKID=0 instance
  logic        n_rst_n, n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_stall, n_flush;
  logic [31:0] n_in_data, n_out_data;
  logic [1:0]  n_occ;

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b1)) u_skid (
    .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .stall(s_stall), .flush(s_flush), .occupancy(s_occ)
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b0)) u_noskid (
    .clk(clk), .rst_n(n_rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_data(n_in_data), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_data(n_out_data), .stall(n_stall), .flush(n_flush), .occupancy(n_occ)
  );

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        st;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  eocc;
    logic        eir;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic r, logic iv, logic [31:0] d, logic o, logic st, logic fl,
                              logic ev, logic [31:0] ed, logic [1:0] eo, logic eir);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.d = d; v.ordy = o; v.st = st; v.fl = fl;
    v.ev = ev; v.ed = ed; v.eocc = eo; v.eir = eir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_stall = 1'b0; s_flush = 1'b0;
    n_rst_n = 1'b0; n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0; n_stall = 1'b0; n_flush = 1'b0;

    //            rst iv data    ordy st fl   ev data  occ ir
    vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0,  0, 32'h0,   0, 1)); // reset
    vecs.push_back(mk(1, 0, 32'h0,   0, 0, 0,  0, 32'h0,   0, 1));
    vecs.push_back(mk(1, 1, 32'h100, 1, 0, 0,  1, 32'h100, 1, 1)); // streaming
    vecs.push_back(mk(1, 1, 32'h104, 1, 0, 0,  1, 32'h104, 1, 1));
    vecs.push_back(mk(1, 1, 32'h108, 1, 0, 0,  1, 32'h108, 1, 1));
    vecs.push_back(mk(1, 0, 32'h0,   1, 0, 0,  0, 32'h0,   0, 1));
    vecs.push_back(mk(1, 1, 32'hA,   0, 0, 0,  1, 32'hA,   1, 1)); // backpressure
    vecs.push_back(mk(1, 1, 32'hB,   0, 0, 0,  1, 32'hA,   2, 0));
    vecs.push_back(mk(1, 1, 32'h77,  0, 0, 0,  1, 32'hA,   2, 0)); // full: 0x77 refused
    vecs.push_back(mk(1, 0, 32'h0,   1, 0, 0,  1, 32'hB,   1, 1));
    vecs.push_back(mk(1, 0, 32'h0,   1, 0, 0,  0, 32'h0,   0, 1));
    vecs.push_back(mk(1, 1, 32'hC,   1, 0, 0,  1, 32'hC,   1, 1)); // stall
    vecs.push_back(mk(1, 0, 32'h0,   1, 1, 0,  1, 32'hC,   1, 1));
    vecs.push_back(mk(1, 1, 32'hD,   1, 1, 0,  1, 32'hC,   2, 0));
    vecs.push_back(mk(1, 0, 32'h0,   1, 1, 0,  1, 32'hC,   2, 0));
    vecs.push_back(mk(1, 0, 32'h0,   1, 0, 0,  1, 32'hD,   1, 1));
    vecs.push_back(mk(1, 0, 32'h0,   1, 0, 0,  0, 32'h0,   0, 1));
    vecs.push_back(mk(1, 1, 32'hE,   0, 0, 0,  1, 32'hE,   1, 1)); // flush while full
    vecs.push_back(mk(1, 1, 32'hF,   0, 0, 0,  1, 32'hE,   2, 0));
    vecs.push_back(mk(1, 1, 32'h10,  0, 0, 1,  0, 32'h0,   0, 1));
    vecs.push_back(mk(1, 0, 32'h0,   0, 0, 0,  0, 32'h0,   0, 1));
    vecs.push_back(mk(1, 1, 32'h20,  0, 0, 0,  1, 32'h20,  1, 1)); // flush drops same-cycle accept
    vecs.push_back(mk(1, 1, 32'h30,  0, 0, 1,  0, 32'h0,   0, 1));
    vecs.push_back(mk(1, 0, 32'h0,   1, 0, 0,  0, 32'h0,   0, 1));
    vecs.push_back(mk(1, 1, 32'h1,   0, 0, 0,  1, 32'h1,   1, 1)); // reset mid-stream at occ=2
    vecs.push_back(mk(1, 1, 32'h2,   0, 0, 0,  1, 32'h1,   2, 0));
    vecs.push_back(mk(0, 1, 32'h3,   1, 0, 0,  0, 32'h0,   0, 1));
    vecs.push_back(mk(1, 0, 32'h0,   0, 0, 0,  0, 32'h0,   0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      s_rst_n = vecs[i].rst_n; s_in_valid = vecs[i].iv; s_in_data = vecs[i].d;
      s_out_ready = vecs[i].ordy; s_stall = vecs[i].st; s_flush = vecs[i].fl;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), {31'd0, s_out_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d out_data", i), s_out_data, vecs[i].ed);
      chk($sformatf("v%0d occupancy", i), {30'd0, s_occ}, {30'd0, vecs[i].eocc});
      chk($sformatf("v%0d in_ready", i), {31'd0, s_in_ready}, {31'd0, vecs[i].eir});
    end
    s_rst_n = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b0; s_stall = 1'b0; s_flush = 1'b0;

    // SKID=0: combinational in_ready and same-cycle replace
    @(posedge clk); #1;
    chk("ns reset out_valid", {31'd0, n_out_valid}, 32'd0);
    chk("ns reset occupancy", {30'd0, n_occ}, 32'd0);
    n_rst_n = 1'b1; n_in_valid = 1'b1; n_in_data = 32'h55; n_out_ready = 1'b0;
    #1;
    chk("ns empty in_ready", {31'd0, n_in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("ns load out_data", n_out_data, 32'h55);
    chk("ns load occupancy", {30'd0, n_occ}, 32'd1);
    n_in_data = 32'h66;
    #1;
    chk("ns full blocked in_ready", {31'd0, n_in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ns hold out_data", n_out_data, 32'h55);
    n_out_ready = 1'b1; n_stall = 1'b1;
    #1;
    chk("ns stall in_ready", {31'd0, n_in_ready}, 32'd0);
    n_stall = 1'b0; n_in_data = 32'h77;
    #1;
    chk("ns take in_ready", {31'd0, n_in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("ns replace out_data", n_out_data, 32'h77);
    chk("ns replace occupancy", {30'd0, n_occ}, 32'd1);
    n_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ns drain out_valid", {31'd0, n_out_valid}, 32'd0);
    chk("ns drain out_data", n_out_data, 32'h0);
    chk("ns drain occupancy", {30'd0, n_occ}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
